keypad_time_entry: RTL and testbench

- Input-side counterpart of the six-digit time display driver. It scans a 4x4 matrix keypad, debounces presses, and decodes them into key codes.
- Key codes are assembled into an HH:MM:SS value, which is presented as binary hour/minute/second with a one-cycle load strobe.
- Feeds the clock core's time-set path. The display driver then shows the loaded value.

---
 rtl/keypad_time_entry_if.sv | 69 ++++++
 rtl/keypad_time_entry.sv | 366 ++++++++++++++++++++++++++++++++++++
 tb/tb_keypad_time_entry.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_time_entry_if.sv
// ----------------------------------------------------------------------------
// keypad_time_entry_if
//
// Bundles every signal between the keypad time-entry block and its
// surroundings: the matrix keypad (row_in / col_out) and the clock core's
// time-set path (key and time outputs), plus the debounce FSM state for
// observation.
//
// Handshake semantics: key_valid and time_load are single-cycle strobes with
// no back-pressure. key_valid qualifies key_code and time_load qualifies
// hour/minute/second in the cycle they are high. A consumer must capture on
// the strobe; there is no ready and nothing is held or retried. key_code and
// hour/minute/second keep their last value between strobes.
//
// Signals:
//   row_in       keypad rows, active-low, externally pulled up
//   col_out      column drive, active-low, exactly one bit low
//   key_valid    one-cycle pulse per accepted key
//   key_code     code of the last accepted key
//   entry_active high while a time entry is in progress
//   time_load    one-cycle pulse when hour/minute/second update
//   hour         0-23 binary
//   minute       0-59 binary
//   second       0-59 binary
//   dbg_state    debounce FSM state (0 released, 1 press wait, 2 held,
//                3 release wait)
//
// Modports:
//   master  the keypad_time_entry block
//   slave   the environment (keypad + clock core)
// ----------------------------------------------------------------------------
interface keypad_time_entry_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       key_valid;
   logic [3:0] key_code;
   logic       entry_active;
   logic       time_load;
   logic [5:0] hour;
   logic [5:0] minute;
   logic [5:0] second;
   logic [1:0] dbg_state;

   modport master (
      input  row_in,
      output col_out,
      output key_valid,
      output key_code,
      output entry_active,
      output time_load,
      output hour,
      output minute,
      output second,
      output dbg_state
   );

   modport slave (
      output row_in,
      input  col_out,
      input  key_valid,
      input  key_code,
      input  entry_active,
      input  time_load,
      input  hour,
      input  minute,
      input  second,
      input  dbg_state
   );
endinterface

// File: rtl/keypad_time_entry.sv
// ----------------------------------------------------------------------------
// keypad_time_entry
//
// Scans a 4x4 matrix keypad, debounces presses over whole scans, decodes them
// into key codes and assembles an HH:MM:SS entry that is presented as binary
// hour/minute/second with a one-cycle time_load strobe.
//
// Key entry: '*' starts an entry, six digits H1 H0 M1 M0 S1 S0 follow, '#'
// commits (only if the value is a legal time), 'D' cancels. A/B/C are
// reported on key_valid/key_code but ignored by the entry logic.
//
// Parameters:
//   SCAN_PERIOD     clk cycles each column is driven (>= 4, which covers the
//                   two-flop row synchronizer latency before sampling)
//   DEBOUNCE_SCANS  identical full scans needed to accept a press or release
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-low
//   kp    keypad_time_entry_if.master (keypad, key and time outputs,
//         debounce state)
//
// Optional build macro: KEYPAD_AUTOREPEAT_EN
//   When defined, a key held for 64 consecutive scans re-pulses key_valid
//   every 16 scans with the same key_code; the entry logic treats each
//   repeat as a press. Without it there is exactly one pulse per press.
// ----------------------------------------------------------------------------
module keypad_time_entry #(
   parameter int SCAN_PERIOD    = 200000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input logic                 clk,
   input logic                 rst,
   keypad_time_entry_if.master kp
);

   localparam int DW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_PERIOD - 1);
   localparam logic [CW-1:0] DEB_C      = CW'(DEBOUNCE_SCANS);

   localparam logic [3:0] KC_STAR  = 4'd14;
   localparam logic [3:0] KC_HASH  = 4'd15;
   localparam logic [3:0] KC_D     = 4'd13;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } db_state_t;

   // Keypad position (row*4 + column) to key code.
   function automatic logic [3:0] key_map(input logic [3:0] idx);
      logic [3:0] code;
      case (idx)
         4'd0:    code = 4'd1;
         4'd1:    code = 4'd2;
         4'd2:    code = 4'd3;
         4'd3:    code = 4'd10;
         4'd4:    code = 4'd4;
         4'd5:    code = 4'd5;
         4'd6:    code = 4'd6;
         4'd7:    code = 4'd11;
         4'd8:    code = 4'd7;
         4'd9:    code = 4'd8;
         4'd10:   code = 4'd9;
         4'd11:   code = 4'd12;
         4'd12:   code = 4'd14;
         4'd13:   code = 4'd0;
         4'd14:   code = 4'd15;
         default: code = 4'd13;
      endcase
      return code;
   endfunction

   // Two BCD digits to binary (10*hi + lo); 7 bits covers 99.
   function automatic logic [6:0] tens(input logic [3:0] hi, input logic [3:0] lo);
      return {hi, 3'b000} + {2'b00, hi, 1'b0} + {3'b000, lo};
   endfunction

   // ------------------------------------------------------------------
   // Row synchronizer
   // ------------------------------------------------------------------
   logic [3:0] row_s1, row_s2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= kp.row_in;
         row_s2 <= row_s1;
      end
   end

   // ------------------------------------------------------------------
   // Column scan
   // ------------------------------------------------------------------
   logic [DW-1:0] dwell_q;
   logic [1:0]    col_q;
   logic          sample;
   logic          scan_end;

   assign sample   = (dwell_q == DWELL_LAST);
   assign scan_end = sample && (col_q == 2'd3);

   always_ff @(posedge clk) begin
      if (!rst) begin
         dwell_q <= '0;
         col_q   <= 2'd0;
      end else if (sample) begin
         dwell_q <= '0;
         col_q   <= col_q + 2'd1;
      end else begin
         dwell_q <= dwell_q + DW'(1);
      end
   end

   assign kp.col_out = ~(4'b0001 << col_q);

   // ------------------------------------------------------------------
   // Scan result accumulation. hits saturates at 2 (= more than one),
   // idx remembers the position of the single hit seen so far.
   // ------------------------------------------------------------------
   logic [1:0] acc_hits;
   logic [3:0] acc_idx;
   logic [2:0] cur_cnt;
   logic [1:0] cur_row;
   logic [1:0] tot_hits;
   logic [3:0] hit_idx;
   logic       scan_single;

   always_comb begin
      cur_cnt = 3'd0;
      cur_row = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (!row_s2[r]) begin
            cur_cnt = cur_cnt + 3'd1;
            cur_row = 2'(r);
         end
      end
   end

   always_comb begin
      if ((cur_cnt >= 3'd2) || (acc_hits == 2'd2) ||
          ((cur_cnt == 3'd1) && (acc_hits == 2'd1)))
         tot_hits = 2'd2;
      else if ((cur_cnt == 3'd1) || (acc_hits == 2'd1))
         tot_hits = 2'd1;
      else
         tot_hits = 2'd0;
      hit_idx = (cur_cnt == 3'd1) ? {cur_row, col_q} : acc_idx;
   end

   assign scan_single = (tot_hits == 2'd1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_hits <= 2'd0;
         acc_idx  <= 4'd0;
      end else if (sample) begin
         if (scan_end) begin
            acc_hits <= 2'd0;
            acc_idx  <= 4'd0;
         end else begin
            acc_hits <= tot_hits;
            acc_idx  <= hit_idx;
         end
      end
   end

   // ------------------------------------------------------------------
   // Debounce FSM, advanced once per completed scan (scan_end).
   // MULTI is folded into "not single" so it behaves as NONE.
   // ------------------------------------------------------------------
   db_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    cand_q, cand_d;
   logic          press_fire;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_RELEASED;
         cnt_q   <= '0;
         cand_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      if (scan_end) begin
         case (state_q)
            ST_RELEASED: begin
               if (scan_single) begin
                  cand_d  = hit_idx;
                  cnt_d   = CW'(1);
                  state_d = (DEBOUNCE_SCANS <= 1) ? ST_HELD : ST_PRESS_WAIT;
               end
            end
            ST_PRESS_WAIT: begin
               if (!scan_single) begin
                  cnt_d   = '0;
                  state_d = ST_RELEASED;
               end else if (hit_idx != cand_q) begin
                  cand_d = hit_idx;
                  cnt_d  = CW'(1);
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_d >= DEB_C)
                     state_d = ST_HELD;
               end
            end
            ST_HELD: begin
               // Key changes while held are absorbed silently.
               if (!scan_single) begin
                  cnt_d   = CW'(1);
                  state_d = (DEBOUNCE_SCANS <= 1) ? ST_RELEASED : ST_RELEASE_WAIT;
               end
            end
            ST_RELEASE_WAIT: begin
               if (scan_single) begin
                  state_d = ST_HELD;
               end else begin
                  cnt_d = cnt_q + CW'(1);
                  if (cnt_d >= DEB_C)
                     state_d = ST_RELEASED;
               end
            end
            default: state_d = ST_RELEASED;
         endcase
      end
   end

   // A press is accepted only when HELD is entered from the press side;
   // RELEASE_WAIT -> HELD is the same press continuing.
   always_comb begin
      press_fire = scan_end && (state_d == ST_HELD) &&
                   ((state_q == ST_RELEASED) || (state_q == ST_PRESS_WAIT));
   end

   assign kp.dbg_state = state_q;

   // ------------------------------------------------------------------
   // Auto-repeat
   // ------------------------------------------------------------------
   logic rep_fire;

`ifdef KEYPAD_AUTOREPEAT_EN
   logic [5:0] rep_q;

   // rep_q counts scans spent in HELD; the first repeat fires on the 64th,
   // then reloading 48 makes every 16th scan after that fire again.
   assign rep_fire = scan_end && (state_q == ST_HELD) && (state_d == ST_HELD) &&
                     (rep_q == 6'd63);

   always_ff @(posedge clk) begin
      if (!rst) begin
         rep_q <= 6'd0;
      end else if (state_q != ST_HELD) begin
         rep_q <= 6'd0;
      end else if (scan_end) begin
         if (state_d != ST_HELD)
            rep_q <= 6'd0;
         else if (rep_q == 6'd63)
            rep_q <= 6'd48;
         else
            rep_q <= rep_q + 6'd1;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Key output
   // ------------------------------------------------------------------
   logic       fire;
   logic [3:0] fire_code;
   logic       key_valid_q;
   logic [3:0] key_code_q;

   assign fire      = press_fire | rep_fire;
   assign fire_code = press_fire ? key_map(cand_d) : key_code_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         key_valid_q <= 1'b0;
         key_code_q  <= 4'd0;
      end else begin
         key_valid_q <= fire;
         if (fire)
            key_code_q <= fire_code;
      end
   end

   assign kp.key_valid = key_valid_q;
   assign kp.key_code  = key_code_q;

   // ------------------------------------------------------------------
   // Time entry. Acts on the same edge that raises key_valid, so time_load
   // and the new hour/minute/second appear in the key_valid cycle of '#'.
   // ------------------------------------------------------------------
   logic [23:0] buf_q;
   logic [2:0]  dcnt_q;
   logic        active_q;
   logic        time_load_q;
   logic [5:0]  hour_q, minute_q, second_q;
   logic [6:0]  h_val, m_val, s_val;
   logic        entry_ok;

   assign h_val    = tens(buf_q[23:20], buf_q[19:16]);
   assign m_val    = tens(buf_q[15:12], buf_q[11:8]);
   assign s_val    = tens(buf_q[7:4],   buf_q[3:0]);
   assign entry_ok = (dcnt_q == 3'd6) && (h_val < 7'd24) &&
                     (m_val < 7'd60) && (s_val < 7'd60);

   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_q       <= 24'd0;
         dcnt_q      <= 3'd0;
         active_q    <= 1'b0;
         time_load_q <= 1'b0;
         hour_q      <= 6'd0;
         minute_q    <= 6'd0;
         second_q    <= 6'd0;
      end else begin
         time_load_q <= 1'b0;
         if (fire) begin
            if (fire_code == KC_STAR) begin
               buf_q    <= 24'd0;
               dcnt_q   <= 3'd0;
               active_q <= 1'b1;
            end else if (fire_code <= 4'd9) begin
               if (active_q && (dcnt_q < 3'd6)) begin
                  buf_q  <= {buf_q[19:0], fire_code};
                  dcnt_q <= dcnt_q + 3'd1;
               end
            end else if (fire_code == KC_D) begin
               active_q <= 1'b0;
            end else if ((fire_code == KC_HASH) && active_q) begin
               active_q <= 1'b0;
               if (entry_ok) begin
                  hour_q      <= h_val[5:0];
                  minute_q    <= m_val[5:0];
                  second_q    <= s_val[5:0];
                  time_load_q <= 1'b1;
               end
            end
         end
      end
   end

   assign kp.entry_active = active_q;
   assign kp.time_load    = time_load_q;
   assign kp.hour         = hour_q;
   assign kp.minute       = minute_q;
   assign kp.second       = second_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// ----------------------------------------------------------------------------
// tb_keypad_time_entry
//
// Directed bench for keypad_time_entry with SCAN_PERIOD=4, DEBOUNCE_SCANS=2
// (one full scan = 16 clk cycles). A behavioural keypad pulls a row low when
// a pressed key sits in the currently driven column. Keys are pressed and
// released on scan boundaries so every expected value is a hand count of
// scans.
// ----------------------------------------------------------------------------
module tb_keypad_time_entry;

   logic        clk;
   logic        rst;
   logic [15:0] pressed;
   logic [3:0]  row_model;

   int n_cmp;
   int n_bad;
   int cyc;
   int kv_cnt;
   int tl_cnt;
   logic [3:0] last_code;
   logic [5:0] ld_h, ld_m, ld_s;
   logic [3:0] exp_col;

   keypad_time_entry_if kp ();

   keypad_time_entry #(
      .SCAN_PERIOD    (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kp.master)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- keypad model ----------------
   always_comb begin
      row_model = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kp.col_out[c] && pressed[r*4 + c])
               row_model[r] = 1'b0;
   end
   assign kp.row_in = row_model;

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Advance n clk cycles, observing on the falling edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (kp.key_valid === 1'b1) begin
            kv_cnt++;
            last_code = kp.key_code;
         end
         if (kp.time_load === 1'b1) begin
            tl_cnt++;
            ld_h = kp.hour;
            ld_m = kp.minute;
            ld_s = kp.second;
         end
      end
   endtask

   // Press for 2 scans (accepted at the end of the 2nd), release for 2.
   task automatic press_key(input int idx);
      pressed = 16'd1 << idx;
      step(32);
      pressed = 16'd0;
      step(32);
   endtask

   // Key positions (row*4 + col)
   localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5;
   localparam int K7 = 8, K8 = 9, K9 = 10, KSTAR = 12, K0 = 13, KHASH = 14, KD = 15;

   // ---------------- directed sequence ----------------
   initial begin
      n_cmp = 0; n_bad = 0; cyc = 0; kv_cnt = 0; tl_cnt = 0;
      last_code = 4'd0; ld_h = 6'd0; ld_m = 6'd0; ld_s = 6'd0;
      pressed = 16'd0;
      rst = 1'b0;
      step(3);

      // Reset state
      chk("rst_col_out",   32'(kp.col_out),      32'hE);
      chk("rst_key_valid", 32'(kp.key_valid),    0);
      chk("rst_key_code",  32'(kp.key_code),     0);
      chk("rst_entry",     32'(kp.entry_active), 0);
      chk("rst_time_load", 32'(kp.time_load),    0);
      chk("rst_hour",      32'(kp.hour),         0);
      chk("rst_minute",    32'(kp.minute),       0);
      chk("rst_second",    32'(kp.second),       0);
      chk("rst_state",     32'(kp.dbg_state),    0);

      rst = 1'b1;
      cyc = 0;

      // Idle scan: column rotates every 4 cycles
      for (int k = 1; k <= 16; k++) begin
         step(1);
         exp_col = 4'b0001 << ((k / 4) % 4);
         exp_col = ~exp_col;
         chk("idle_col_out", 32'(kp.col_out), 32'(exp_col));
      end
      step(16);
      chk("idle_no_key", kv_cnt, 0);

      // Key '5' held 5 scans: one pulse, visible right after the 2nd scan
      kv_cnt = 0;
      pressed = 16'd1 << K5;
      step(32);
      chk("k5_latency_valid", 32'(kp.key_valid), 1);
      chk("k5_code",          32'(kp.key_code),  5);
      chk("k5_state_held",    32'(kp.dbg_state), 2);
      step(48);
      chk("k5_one_pulse", kv_cnt, 1);
      pressed = 16'd0;
      step(48);
      chk("k5_released_state", 32'(kp.dbg_state), 0);
      chk("k5_no_release_pulse", kv_cnt, 1);
      pressed = 16'd1 << K5;
      step(32);
      chk("k5_second_press", kv_cnt, 2);
      pressed = 16'd0;
      step(48);

      // Key '8' bouncing every other scan, then stable
      kv_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         pressed = 16'd1 << K8;
         step(16);
         pressed = 16'd0;
         step(16);
      end
      chk("k8_bounce_none", kv_cnt, 0);
      pressed = 16'd1 << K8;
      step(32);
      chk("k8_stable_pulse", kv_cnt, 1);
      chk("k8_code", 32'(last_code), 8);
      pressed = 16'd0;
      step(48);

      // '1' and '2' together: MULTI
      kv_cnt = 0;
      pressed = (16'd1 << K1) | (16'd1 << K2);
      step(64);
      chk("multi_no_pulse", kv_cnt, 0);
      chk("multi_state",    32'(kp.dbg_state), 0);
      chk("multi_code_hold", 32'(kp.key_code), 8);
      pressed = 16'd0;
      step(32);

      // * 2 3 5 9 4 7 #  -> 23:59:47
      tl_cnt = 0;
      press_key(KSTAR);
      chk("entry_active_star", 32'(kp.entry_active), 1);
      press_key(K2); press_key(K3); press_key(K5);
      press_key(K9); press_key(K4); press_key(K7);
      press_key(KHASH);
      chk("load_pulses", tl_cnt, 1);
      chk("load_hour",   32'(ld_h), 23);
      chk("load_minute", 32'(ld_m), 59);
      chk("load_second", 32'(ld_s), 47);
      chk("load_entry_idle", 32'(kp.entry_active), 0);
      chk("load_hash_code",  32'(kp.key_code), 15);

      // * 2 4 0 0 0 0 #  -> hour 24 invalid
      tl_cnt = 0;
      press_key(KSTAR);
      press_key(K2); press_key(K4); press_key(K0);
      press_key(K0); press_key(K0); press_key(K0);
      press_key(KHASH);
      chk("bad_no_load", tl_cnt, 0);
      chk("bad_hour",   32'(kp.hour),   23);
      chk("bad_minute", 32'(kp.minute), 59);
      chk("bad_second", 32'(kp.second), 47);

      // * 1 2 D #  -> cancelled
      tl_cnt = 0;
      press_key(KSTAR); press_key(K1); press_key(K2);
      press_key(KD);
      chk("cancel_entry", 32'(kp.entry_active), 0);
      chk("cancel_code",  32'(kp.key_code), 13);
      press_key(KHASH);
      chk("cancel_no_load", tl_cnt, 0);

      // Reset mid-entry and mid-scan
      press_key(KSTAR); press_key(K1); press_key(K2);
      chk("pre_rst_entry", 32'(kp.entry_active), 1);
      step(5);
      rst = 1'b0;
      step(2);
      chk("midrst_entry",   32'(kp.entry_active), 0);
      chk("midrst_col_out", 32'(kp.col_out), 32'hE);
      chk("midrst_hour",    32'(kp.hour), 0);
      chk("midrst_code",    32'(kp.key_code), 0);
      rst = 1'b1;
      cyc = 0;

      // '#' right after reset is ignored (no entry in progress)
      tl_cnt = 0;
      press_key(KHASH);
      chk("post_rst_hash", tl_cnt, 0);

      // * 0 1 A 0 2 0 3 #  -> 01:02:03, 'A' ignored
      press_key(KSTAR);
      press_key(K0); press_key(K1); press_key(KA);
      press_key(K0); press_key(K2); press_key(K0); press_key(K3);
      press_key(KHASH);
      chk("reload_pulses", tl_cnt, 1);
      chk("reload_hour",   32'(ld_h), 1);
      chk("reload_minute", 32'(ld_m), 2);
      chk("reload_second", 32'(ld_s), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
